// File: rtl/kick_if.sv
// kick_if: CPU/sensor-side request and solenoid-drive bundle for kick_controller (force_i only with KICK_FORCE_EN).
interface kick_if #(
  parameter int NCH = 2,
  parameter int PW  = 32
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  logic           arm_i;
  logic [CW-1:0]  ch_sel_i;
  logic [PW-1:0]  pulse_len_i;
  logic           detect_i;
  logic           cap_ok_i;
`ifdef KICK_FORCE_EN
  logic           force_i;
`endif
  logic [NCH-1:0] dout_o;
  logic           done_o;
  logic           armed_o;
  logic           busy_o;
  logic           err_o;
  modport master (
`ifdef KICK_FORCE_EN
    output force_i,
`endif
    output arm_i, ch_sel_i, pulse_len_i, detect_i, cap_ok_i,
    input  dout_o, done_o, armed_o, busy_o, err_o
  );
  modport slave (
`ifdef KICK_FORCE_EN
    input  force_i,
`endif
    input  arm_i, ch_sel_i, pulse_len_i, detect_i, cap_ok_i,
    output dout_o, done_o, armed_o, busy_o, err_o
  );
endinterface

// File: rtl/kick_controller.sv
// kick_controller: multi-channel kicker driver (arm/fire/cooldown, pulse clamp, charge interlock).
// Define KICK_FORCE_EN to let force_i fire an armed shot without detect_i.
module kick_controller #(
  parameter int NCH         = 2,
  parameter int PW          = 32,
  parameter int MAX_PULSE   = 200000,
  parameter int ARM_TIMEOUT = 50000000,
  parameter int DONE_LEN    = 1600,
  parameter int COOLDOWN    = 100000
) (
  input logic  clk,
  input logic  reset,
  kick_if.slave k
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, COOL} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [PW-1:0] len_q, len_d, cnt_q, cnt_d, dcnt_q, dcnt_d, cnt_inc, len_clamp;
  logic          err_q, err_d, valid, fire;
  assign valid     = int'(k.ch_sel_i) < NCH && k.pulse_len_i != '0;
  assign len_clamp = (k.pulse_len_i > PW'(MAX_PULSE)) ? PW'(MAX_PULSE) : k.pulse_len_i;
  assign cnt_inc   = cnt_q + PW'(cnt_q != '1);
`ifdef KICK_FORCE_EN
  assign fire = k.cap_ok_i && (k.detect_i || k.force_i);
`else
  assign fire = k.cap_ok_i && k.detect_i;
`endif
  // cnt_q is shared: arm-idle timer in ARMED, pulse timer in FIRE, hold-off in COOL
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    len_d   = len_q;
    cnt_d   = cnt_inc;
    err_d   = 1'b0;
    dcnt_d  = dcnt_q - PW'(dcnt_q != '0);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = k.arm_i && !valid;
        if (k.arm_i && valid) begin
          ch_d    = k.ch_sel_i;
          len_d   = len_clamp;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (k.arm_i) begin
          err_d = !valid;
          cnt_d = valid ? '0 : cnt_q;
          ch_d  = valid ? k.ch_sel_i : ch_q;
          len_d = valid ? len_clamp : len_q;
        end else if (fire) begin
          state_d = FIRE;
          cnt_d   = '0;
          dcnt_d  = PW'(DONE_LEN);
        end else if (cnt_q == PW'(ARM_TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      FIRE: begin
        err_d = k.arm_i;
        if (cnt_q == len_q - 1'b1) begin
          state_d = (COOLDOWN == 0) ? IDLE : COOL;
          cnt_d   = '0;
        end
      end
      COOL: begin
        err_d = k.arm_i;
        if (cnt_q == PW'(COOLDOWN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end
  assign k.dout_o  = (state_q == FIRE) ? NCH'(1) << ch_q : '0;
  assign k.done_o  = dcnt_q != '0;
  assign k.armed_o = state_q == ARMED;
  assign k.busy_o  = state_q == FIRE || state_q == COOL;
  assign k.err_o   = err_q;
endmodule

// File: tb/tb_kick_controller.sv
// tb_kick_controller: directed scenario bench for kick_controller (MAX_PULSE=1000, ARM_TIMEOUT=100, DONE_LEN=16, COOLDOWN=50).
module tb_kick_controller;
  logic clk = 1'b0;
  logic reset;
  int   vec = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  kick_if #(.NCH(2), .PW(32)) k();
  kick_controller #(
    .NCH(2), .PW(32), .MAX_PULSE(1000), .ARM_TIMEOUT(100), .DONE_LEN(16), .COOLDOWN(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .k(k)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_req(input logic ch, input int len);
    k.ch_sel_i    = ch;
    k.pulse_len_i = len;
    k.arm_i       = 1'b1;
    tick();
    k.arm_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    arm_req(1'b1, 20);
    tick();
    vec++; if (k.dout_o !== 2'b00) begin bad++; $display("FAIL reset_dout got=%b exp=00", k.dout_o); end
    vec++; if ({k.done_o, k.armed_o, k.busy_o, k.err_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {k.done_o, k.armed_o, k.busy_o, k.err_o});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int nd = 0, ndn = 0, nb = 0;
    arm_req(1'b1, 20);
    vec++; if (k.armed_o !== 1'b1) begin bad++; $display("FAIL basic_armed got=%b exp=1", k.armed_o); end
    repeat (9) tick();
    k.detect_i = 1'b1;
    tick();
    k.detect_i = 1'b0;
    vec++; if (k.dout_o !== 2'b10) begin bad++; $display("FAIL basic_latency got=%b exp=10", k.dout_o); end
    for (int i = 0; i < 100; i++) begin
      nd  += int'(k.dout_o == 2'b10);
      ndn += int'(k.done_o);
      nb  += int'(k.busy_o);
      tick();
    end
    vec++; if (nd != 20) begin bad++; $display("FAIL basic_dout_len got=%0d exp=20", nd); end
    vec++; if (ndn != 16) begin bad++; $display("FAIL basic_done_len got=%0d exp=16", ndn); end
    vec++; if (nb != 70) begin bad++; $display("FAIL basic_busy_len got=%0d exp=70", nb); end
  endtask

  task automatic test_clamp;
    int nd = 0, nb = 0;
    arm_req(1'b0, 5000);
    k.detect_i = 1'b1;
    tick();
    k.detect_i = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      nd += int'(k.dout_o == 2'b01);
      nb += int'(k.busy_o);
      tick();
    end
    vec++; if (nd != 1000) begin bad++; $display("FAIL clamp_dout_len got=%0d exp=1000", nd); end
    vec++; if (nb != 1050) begin bad++; $display("FAIL clamp_busy_len got=%0d exp=1050", nb); end
  endtask

  task automatic test_err;
    arm_req(1'b0, 0);
    vec++; if (k.err_o !== 1'b1) begin bad++; $display("FAIL err_len0 got=%b exp=1", k.err_o); end
    vec++; if (k.armed_o !== 1'b0) begin bad++; $display("FAIL err_armed got=%b exp=0", k.armed_o); end
    vec++; if (k.dout_o !== 2'b00) begin bad++; $display("FAIL err_dout got=%b exp=00", k.dout_o); end
    tick();
    vec++; if (k.err_o !== 1'b0) begin bad++; $display("FAIL err_width got=%b exp=0", k.err_o); end
  endtask

  task automatic test_timeout;
    int na = 0;
    arm_req(1'b1, 10);
    for (int i = 0; i < 150; i++) begin
      na += int'(k.armed_o);
      tick();
    end
    vec++; if (na != 100) begin bad++; $display("FAIL timeout_armed_len got=%0d exp=100", na); end
    vec++; if (k.err_o !== 1'b0) begin bad++; $display("FAIL timeout_err got=%b exp=0", k.err_o); end
    k.detect_i = 1'b1;
    repeat (3) tick();
    k.detect_i = 1'b0;
    vec++; if (k.dout_o !== 2'b00 || k.busy_o !== 1'b0) begin
      bad++; $display("FAIL timeout_no_fire got dout=%b busy=%b exp dout=00 busy=0", k.dout_o, k.busy_o);
    end
  endtask

  task automatic test_interlock;
    k.cap_ok_i = 1'b0;
    arm_req(1'b0, 8);
    k.detect_i = 1'b1;
    repeat (5) tick();
    vec++; if (k.dout_o !== 2'b00 || k.armed_o !== 1'b1) begin
      bad++; $display("FAIL interlock_hold got dout=%b armed=%b exp dout=00 armed=1", k.dout_o, k.armed_o);
    end
    k.cap_ok_i = 1'b1;
    tick();
    k.detect_i = 1'b0;
    vec++; if (k.dout_o !== 2'b01) begin bad++; $display("FAIL interlock_fire got=%b exp=01", k.dout_o); end
    repeat (8) tick();
    vec++; if (k.dout_o !== 2'b00 || k.busy_o !== 1'b1) begin
      bad++; $display("FAIL interlock_cool got dout=%b busy=%b exp dout=00 busy=1", k.dout_o, k.busy_o);
    end
    arm_req(1'b0, 5);
    vec++; if (k.err_o !== 1'b1) begin bad++; $display("FAIL cool_arm_err got=%b exp=1", k.err_o); end
    repeat (60) tick();
    vec++; if (k.busy_o !== 1'b0 || k.armed_o !== 1'b0) begin
      bad++; $display("FAIL cool_discard got busy=%b armed=%b exp busy=0 armed=0", k.busy_o, k.armed_o);
    end
  endtask

  task automatic test_rearm;
    int nd = 0;
    arm_req(1'b0, 4);
    k.ch_sel_i = 1'b1; k.pulse_len_i = 3; k.arm_i = 1'b1; k.detect_i = 1'b1;
    tick();
    vec++; if (k.armed_o !== 1'b1 || k.dout_o !== 2'b00) begin
      bad++; $display("FAIL rearm_priority got armed=%b dout=%b exp armed=1 dout=00", k.armed_o, k.dout_o);
    end
    k.ch_sel_i = 1'b0; k.pulse_len_i = 0;
    tick();
    k.arm_i = 1'b0;
    vec++; if (k.err_o !== 1'b1 || k.armed_o !== 1'b1) begin
      bad++; $display("FAIL armed_invalid got err=%b armed=%b exp err=1 armed=1", k.err_o, k.armed_o);
    end
    tick();
    k.detect_i = 1'b0;
    vec++; if (k.dout_o !== 2'b10) begin bad++; $display("FAIL retain_ch got=%b exp=10", k.dout_o); end
    k.ch_sel_i = 1'b0; k.pulse_len_i = 5; k.arm_i = 1'b1;
    tick();
    k.arm_i = 1'b0;
    vec++; if (k.err_o !== 1'b1 || k.dout_o !== 2'b10) begin
      bad++; $display("FAIL fire_arm_err got err=%b dout=%b exp err=1 dout=10", k.err_o, k.dout_o);
    end
    for (int i = 0; i < 10; i++) begin
      nd += int'(k.dout_o == 2'b10);
      tick();
    end
    vec++; if (nd != 2) begin bad++; $display("FAIL retain_len got=%0d exp=2", nd); end
    repeat (60) tick();
  endtask

  task automatic test_reset_mid_fire;
    arm_req(1'b1, 50);
    k.detect_i = 1'b1;
    tick();
    k.detect_i = 1'b0;
    repeat (5) tick();
    vec++; if (k.dout_o !== 2'b10 || k.done_o !== 1'b1) begin
      bad++; $display("FAIL midfire_pre got dout=%b done=%b exp dout=10 done=1", k.dout_o, k.done_o);
    end
    reset = 1'b0;
    tick();
    vec++; if (k.dout_o !== 2'b00 || k.done_o !== 1'b0 || k.busy_o !== 1'b0) begin
      bad++; $display("FAIL midfire_reset got dout=%b done=%b busy=%b exp 00/0/0", k.dout_o, k.done_o, k.busy_o);
    end
    reset = 1'b1;
    tick();
  endtask

`ifdef KICK_FORCE_EN
  task automatic test_force;
    arm_req(1'b0, 3);
    k.force_i = 1'b1;
    tick();
    k.force_i = 1'b0;
    vec++; if (k.dout_o !== 2'b01) begin bad++; $display("FAIL force_fire got=%b exp=01", k.dout_o); end
    repeat (60) tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    k.arm_i = 1'b0; k.ch_sel_i = '0; k.pulse_len_i = '0; k.detect_i = 1'b0; k.cap_ok_i = 1'b1;
`ifdef KICK_FORCE_EN
    k.force_i = 1'b0;
`endif
    tick();
    test_reset();
    test_basic();
    test_clamp();
    test_err();
    test_timeout();
    test_interlock();
    test_rearm();
    test_reset_mid_fire();
`ifdef KICK_FORCE_EN
    test_force();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
